hpi_otg_responder: RTL and testbench

Device-side responder for the 16-bit EZ-OTG host port interface (HPI): it answers the OTG_* bus that the NIOS-side HPI master drives, exactly as the CY7C67200 HPI port does. It decodes the four HPI registers (DATA, MAILBOX, ADDRESS, STATUS) and backs DATA with an internal auto-incrementing word memory. It provides a local mailbox and interrupt toward an on-chip agent. It serves as an on-FPGA stand-in for the USB chip in bring-up and as the bus model in master-side verification.

---
 rtl/hpi_pkg.sv | 27 ++
 rtl/hpi_strobe_sync.sv | 53 +++++
 rtl/hpi_otg_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_hpi_otg_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hpi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hpi_pkg : HPI register selects, status bit positions, responder states. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package hpi_pkg;

   localparam int HPI_DW = 16;

   typedef enum logic [1:0] {
      HPI_DATA    = 2'd0,
      HPI_MAILBOX = 2'd1,
      HPI_ADDRESS = 2'd2,
      HPI_STATUS  = 2'd3
   } hpi_reg_e;

   localparam int STS_MBX_OUT_FULL = 0;
   localparam int STS_MBX_IN_FULL  = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } hpi_state_e;

endpackage
`default_nettype wire

// File: rtl/hpi_strobe_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hpi_strobe_sync : 2-flop synchronizer for HPI strobes and bus bits, with |
// | a delayed strobe copy for edge detection.  Revision: 1.0                 |
// +--------------------------------------------------------------------------+
module hpi_strobe_sync #(
   parameter int               STB_W   = 3,
   parameter int               BUS_W   = 19,
   parameter logic [BUS_W-1:0] BUS_RST = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [STB_W-1:0] stb_in,
   input  logic [BUS_W-1:0] bus_in,
   output logic [STB_W-1:0] stb_s,
   output logic [STB_W-1:0] stb_p,
   output logic [BUS_W-1:0] bus_s
);

   logic [STB_W-1:0] stb_m_q, stb_m_d, stb_s_q, stb_s_d, stb_p_q, stb_p_d;
   logic [BUS_W-1:0] bus_m_q, bus_m_d, bus_s_q, bus_s_d;

   always_comb begin
      stb_m_d = stb_in;
      stb_s_d = stb_m_q;
      stb_p_d = stb_s_q;
      bus_m_d = bus_in;
      bus_s_d = bus_m_q;
   end

   // Strobes reset high so nothing looks like an access while coming out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stb_m_q <= '1;
         stb_s_q <= '1;
         stb_p_q <= '1;
         bus_m_q <= BUS_RST;
         bus_s_q <= BUS_RST;
      end else begin
         stb_m_q <= stb_m_d;
         stb_s_q <= stb_s_d;
         stb_p_q <= stb_p_d;
         bus_m_q <= bus_m_d;
         bus_s_q <= bus_s_d;
      end
   end

   assign stb_s = stb_s_q;
   assign stb_p = stb_p_q;
   assign bus_s = bus_s_q;

endmodule
`default_nettype wire

// File: rtl/hpi_otg_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hpi_otg_responder : device-side EZ-OTG HPI responder with word memory,   |
// | host/local mailboxes and OTG_INT.  Revision: 1.0                         |
// +--------------------------------------------------------------------------+
module hpi_otg_responder
   import hpi_pkg::*;
#(
   parameter int MEM_WORDS = 1024
) (
   input  logic                         Clk,
   input  logic                         Reset_N,
   inout  wire  [HPI_DW-1:0]            OTG_DATA,
   input  logic [1:0]                   OTG_ADDR,
   input  logic                         OTG_RD_N,
   input  logic                         OTG_WR_N,
   input  logic                         OTG_CS_N,
   input  logic                         OTG_RST_N,
   output logic                         OTG_INT,
   input  logic                         mbx_out_wr,
   input  logic [HPI_DW-1:0]            mbx_out_data,
   output logic [HPI_DW-1:0]            mbx_in_data,
   output logic                         mbx_in_valid,
   input  logic                         mbx_in_ack,
   input  logic [$clog2(MEM_WORDS)-1:0] mem_rd_addr,
   output logic [HPI_DW-1:0]            mem_rd_data
);

   localparam int WA = $clog2(MEM_WORDS);
   localparam int AW = WA + 1;

   logic [2:0]        stb_s, stb_p;
   logic [18:0]       bus_s;
   logic              cs_n_s, rd_n_s, wr_n_s, otg_rst_n_s;
   hpi_reg_e          sel_s;
   logic [HPI_DW-1:0] data_s;

   hpi_strobe_sync #(
      .STB_W   (3),
      .BUS_W   (19),
      .BUS_RST ({1'b1, 18'b0})
   ) u_sync (
      .clk    (Clk),
      .rst_n  (Reset_N),
      .stb_in ({OTG_WR_N, OTG_RD_N, OTG_CS_N}),
      .bus_in ({OTG_RST_N, OTG_ADDR, OTG_DATA}),
      .stb_s  (stb_s),
      .stb_p  (stb_p),
      .bus_s  (bus_s)
   );

   assign cs_n_s      = stb_s[0];
   assign rd_n_s      = stb_s[1];
   assign wr_n_s      = stb_s[2];
   assign otg_rst_n_s = bus_s[18];
   assign sel_s       = hpi_reg_e'(bus_s[17:16]);
   assign data_s      = bus_s[15:0];

   logic rd_act, wr_act, rd_act_p, wr_act_p, rd_start, wr_start;

   // Starting on the edge of the active condition keeps a strobe still held
   // low across an HPI soft reset from re-launching the access.
   assign rd_act   = ~stb_s[0] & ~stb_s[1] &  stb_s[2];
   assign wr_act   = ~stb_s[0] &  stb_s[1] & ~stb_s[2];
   assign rd_act_p = ~stb_p[0] & ~stb_p[1] &  stb_p[2];
   assign wr_act_p = ~stb_p[0] &  stb_p[1] & ~stb_p[2];
   assign rd_start = rd_act & ~rd_act_p;
   assign wr_start = wr_act & ~wr_act_p;

   hpi_state_e        state_q, state_d;
   hpi_reg_e          sel_q, sel_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic              out_full_q, out_full_d;
   logic              in_full_q, in_full_d;
   logic [HPI_DW-1:0] mbx_out_q, mbx_out_d;
   logic [HPI_DW-1:0] mbx_in_q, mbx_in_d;
   logic [HPI_DW-1:0] wdata_q, wdata_d;
   logic [HPI_DW-1:0] rdata_q, rdata_d;
   logic              drive_q, drive_d;
   logic              mem_we;

   logic [HPI_DW-1:0] mem [MEM_WORDS];
   logic [HPI_DW-1:0] mem_hpi_q;
   logic [HPI_DW-1:0] mem_rd_q;

   hpi_reg_e          rsel;
   logic [HPI_DW-1:0] rd_value;
   logic [HPI_DW-1:0] status_word;

   always_comb begin
      status_word                   = '0;
      status_word[STS_MBX_OUT_FULL] = out_full_q;
      status_word[STS_MBX_IN_FULL]  = in_full_q;
   end

   // In IDLE the select is still arriving from the synchronizer, later it is latched
   assign rsel = (state_q == ST_IDLE) ? sel_s : sel_q;

   always_comb begin
      rd_value = '0;
      case (rsel)
         HPI_DATA:    rd_value = mem_hpi_q;
         HPI_MAILBOX: rd_value = mbx_out_q;
         HPI_ADDRESS: rd_value = HPI_DW'(addr_q);
         HPI_STATUS:  rd_value = status_word;
         default:     rd_value = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      addr_d     = addr_q;
      out_full_d = out_full_q;
      in_full_d  = in_full_q;
      mbx_out_d  = mbx_out_q;
      mbx_in_d   = mbx_in_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      drive_d    = drive_q;
      mem_we     = 1'b0;

      if (mbx_in_ack) in_full_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (rd_start) begin
               sel_d   = sel_s;
               rdata_d = rd_value;
               drive_d = 1'b1;
               state_d = ST_READ;
            end else if (wr_start) begin
               sel_d   = sel_s;
               wdata_d = data_s;
               state_d = ST_WRITE;
            end
         end
         ST_READ: begin
            if (cs_n_s || rd_n_s) begin
               drive_d = 1'b0;
               state_d = ST_IDLE;
               case (sel_q)
                  HPI_DATA:    addr_d     = addr_q + AW'(2);
                  HPI_MAILBOX: out_full_d = 1'b0;
                  default:     ;
               endcase
            end else begin
               rdata_d = rd_value;
            end
         end
         ST_WRITE: begin
            if (cs_n_s || wr_n_s) begin
               state_d = ST_IDLE;
               case (sel_q)
                  HPI_DATA: begin
                     mem_we = 1'b1;
                     addr_d = addr_q + AW'(2);
                  end
                  HPI_MAILBOX: begin
                     mbx_in_d  = wdata_q;
                     in_full_d = 1'b1;
                  end
                  HPI_ADDRESS: addr_d = {wdata_q[AW-1:1], 1'b0};
                  default:     ;
               endcase
            end else begin
               wdata_d = data_s;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (mbx_out_wr) begin
         mbx_out_d  = mbx_out_data;
         out_full_d = 1'b1;
      end

      if (!otg_rst_n_s) begin
         state_d    = ST_IDLE;
         addr_d     = '0;
         out_full_d = 1'b0;
         in_full_d  = 1'b0;
         mbx_in_d   = '0;
         drive_d    = 1'b0;
         mem_we     = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q    <= ST_IDLE;
         sel_q      <= HPI_DATA;
         addr_q     <= '0;
         out_full_q <= 1'b0;
         in_full_q  <= 1'b0;
         mbx_out_q  <= '0;
         mbx_in_q   <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         drive_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         addr_q     <= addr_d;
         out_full_q <= out_full_d;
         in_full_q  <= in_full_d;
         mbx_out_q  <= mbx_out_d;
         mbx_in_q   <= mbx_in_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         drive_q    <= drive_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (mem_we) mem[addr_q[AW-1:1]] <= wdata_q;
      mem_hpi_q <= mem[addr_q[AW-1:1]];
   end

   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) mem_rd_q <= '0;
      else          mem_rd_q <= mem[mem_rd_addr];
   end

   assign OTG_DATA     = drive_q ? rdata_q : 'z;
   assign OTG_INT      = out_full_q;
   assign mbx_in_data  = mbx_in_q;
   assign mbx_in_valid = in_full_q;
   assign mem_rd_data  = mem_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_hpi_otg_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hpi_otg_responder : directed self-checking bench for the HPI responder|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_hpi_otg_responder;

   localparam int MEM_WORDS = 1024;
   localparam logic [15:0] FLOAT = 16'hFFFF;

   logic        Clk = 1'b0;
   logic        Reset_N;
   wire  [15:0] otg_data;
   logic [1:0]  otg_addr;
   logic        rd_n, wr_n, cs_n, otg_rst_n;
   logic        otg_int;
   logic        mbx_out_wr;
   logic [15:0] mbx_out_data;
   logic [15:0] mbx_in_data;
   logic        mbx_in_valid;
   logic        mbx_in_ack;
   logic [9:0]  mem_rd_addr;
   logic [15:0] mem_rd_data;

   logic        tb_oe;
   logic [15:0] tb_dout;
   logic [15:0] rv;

   int n_assert = 0;
   int n_fail   = 0;

   // An undriven bus reads as all ones
   pullup (otg_data);
   assign otg_data = tb_oe ? tb_dout : 'z;

   always #5 Clk = ~Clk;

   hpi_otg_responder #(.MEM_WORDS(MEM_WORDS)) dut (
      .Clk          (Clk),
      .Reset_N      (Reset_N),
      .OTG_DATA     (otg_data),
      .OTG_ADDR     (otg_addr),
      .OTG_RD_N     (rd_n),
      .OTG_WR_N     (wr_n),
      .OTG_CS_N     (cs_n),
      .OTG_RST_N    (otg_rst_n),
      .OTG_INT      (otg_int),
      .mbx_out_wr   (mbx_out_wr),
      .mbx_out_data (mbx_out_data),
      .mbx_in_data  (mbx_in_data),
      .mbx_in_valid (mbx_in_valid),
      .mbx_in_ack   (mbx_in_ack),
      .mem_rd_addr  (mem_rd_addr),
      .mem_rd_data  (mem_rd_data)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic hpi_write(input logic [1:0] sel, input logic [15:0] val, input bit ack_commit);
      otg_addr = sel;
      tb_dout  = val;
      tb_oe    = 1'b1;
      cs_n     = 1'b0;
      wr_n     = 1'b0;
      tick(4);
      wr_n = 1'b1;
      cs_n = 1'b1;
      tick(2);
      mbx_in_ack = ack_commit;
      tick(1);
      mbx_in_ack = 1'b0;
      tb_oe      = 1'b0;
      tick(2);
   endtask

   task automatic hpi_read(input logic [1:0] sel, output logic [15:0] val);
      otg_addr = sel;
      cs_n     = 1'b0;
      rd_n     = 1'b0;
      tick(4);
      val  = otg_data;
      rd_n = 1'b1;
      cs_n = 1'b1;
      tick(4);
   endtask

   task automatic local_read(input logic [9:0] a, output logic [15:0] val);
      mem_rd_addr = a;
      tick(1);
      val = mem_rd_data;
   endtask

   initial begin
      Reset_N      = 1'b0;
      otg_addr     = 2'd0;
      rd_n         = 1'b1;
      wr_n         = 1'b1;
      cs_n         = 1'b1;
      otg_rst_n    = 1'b1;
      mbx_out_wr   = 1'b0;
      mbx_out_data = 16'h0;
      mbx_in_ack   = 1'b0;
      mem_rd_addr  = 10'd0;
      tb_oe        = 1'b0;
      tb_dout      = 16'h0;

      tick(3);
      chk("rst_int",     {31'b0, otg_int},      32'h0);
      chk("rst_valid",   {31'b0, mbx_in_valid}, 32'h0);
      chk("rst_in_data", {16'b0, mbx_in_data},  32'h0);
      chk("rst_mem_rd",  {16'b0, mem_rd_data},  32'h0);
      chk("rst_bus",     {16'b0, otg_data},     {16'b0, FLOAT});
      Reset_N = 1'b1;
      tick(3);

      // Auto-increment writes and read-back
      hpi_write(2'd2, 16'h0010, 1'b0);
      hpi_write(2'd0, 16'hBEEF, 1'b0);
      hpi_write(2'd0, 16'hCAFE, 1'b0);
      hpi_read(2'd2, rv);
      chk("addr_after_2wr", {16'b0, rv}, 32'h0014);
      local_read(10'd8, rv);
      chk("mem8", {16'b0, rv}, 32'hBEEF);
      local_read(10'd9, rv);
      chk("mem9", {16'b0, rv}, 32'hCAFE);
      hpi_write(2'd2, 16'h0010, 1'b0);
      hpi_read(2'd0, rv);
      chk("hpi_rd_mem8", {16'b0, rv}, 32'hBEEF);
      hpi_read(2'd0, rv);
      chk("hpi_rd_mem9", {16'b0, rv}, 32'hCAFE);
      hpi_read(2'd2, rv);
      chk("addr_after_2rd", {16'b0, rv}, 32'h0014);

      // Address wrap at the top of memory
      hpi_write(2'd2, 16'h07FE, 1'b0);
      hpi_write(2'd0, 16'h1234, 1'b0);
      hpi_read(2'd2, rv);
      chk("addr_wrap", {16'b0, rv}, 32'h0000);
      local_read(10'd1023, rv);
      chk("mem_top", {16'b0, rv}, 32'h1234);

      // Device-to-host mailbox
      mbx_out_data = 16'h00A5;
      mbx_out_wr   = 1'b1;
      tick(1);
      mbx_out_wr = 1'b0;
      chk("int_set", {31'b0, otg_int}, 32'h1);
      hpi_read(2'd3, rv);
      chk("status_out_full", {16'b0, rv}, 32'h0001);
      hpi_read(2'd1, rv);
      chk("mbx_out_word", {16'b0, rv}, 32'h00A5);
      chk("int_clr", {31'b0, otg_int}, 32'h0);
      hpi_read(2'd3, rv);
      chk("status_empty", {16'b0, rv}, 32'h0000);

      // Host-to-device mailbox, set beats a coincident ack
      hpi_write(2'd1, 16'h5A5A, 1'b0);
      chk("in_valid", {31'b0, mbx_in_valid}, 32'h1);
      chk("in_data",  {16'b0, mbx_in_data},  32'h5A5A);
      hpi_read(2'd3, rv);
      chk("status_in_full", {16'b0, rv}, 32'h0002);
      hpi_write(2'd1, 16'h1111, 1'b1);
      chk("in_valid_set_wins", {31'b0, mbx_in_valid}, 32'h1);
      chk("in_data_2",         {16'b0, mbx_in_data},  32'h1111);
      mbx_in_ack = 1'b1;
      tick(1);
      mbx_in_ack = 1'b0;
      chk("in_valid_ack", {31'b0, mbx_in_valid}, 32'h0);

      // Both strobes low is not an access
      hpi_write(2'd2, 16'h0020, 1'b0);
      otg_addr = 2'd2;
      cs_n = 1'b0;
      rd_n = 1'b0;
      wr_n = 1'b0;
      tick(5);
      chk("both_low_bus", {16'b0, otg_data}, {16'b0, FLOAT});
      cs_n = 1'b1;
      rd_n = 1'b1;
      wr_n = 1'b1;
      tick(4);
      hpi_read(2'd2, rv);
      chk("both_low_addr", {16'b0, rv}, 32'h0020);

      // Read strobe without chip select
      rd_n = 1'b0;
      tick(5);
      chk("no_cs_bus", {16'b0, otg_data}, {16'b0, FLOAT});
      rd_n = 1'b1;
      tick(4);

      // HPI soft reset in the middle of a read
      mbx_out_data = 16'h0033;
      mbx_out_wr   = 1'b1;
      tick(1);
      mbx_out_wr = 1'b0;
      hpi_write(2'd1, 16'h7777, 1'b0);
      chk("pre_rst_valid", {31'b0, mbx_in_valid}, 32'h1);
      otg_addr = 2'd2;
      cs_n = 1'b0;
      rd_n = 1'b0;
      tick(4);
      chk("pre_rst_drive", {16'b0, otg_data}, 32'h0020);
      otg_rst_n = 1'b0;
      tick(3);
      chk("otg_rst_bus", {16'b0, otg_data}, {16'b0, FLOAT});
      rd_n = 1'b1;
      cs_n = 1'b1;
      tick(3);
      otg_rst_n = 1'b1;
      tick(4);
      chk("otg_rst_int",     {31'b0, otg_int},      32'h0);
      chk("otg_rst_valid",   {31'b0, mbx_in_valid}, 32'h0);
      chk("otg_rst_in_data", {16'b0, mbx_in_data},  32'h0);
      hpi_read(2'd2, rv);
      chk("otg_rst_addr", {16'b0, rv}, 32'h0000);
      hpi_read(2'd3, rv);
      chk("otg_rst_status", {16'b0, rv}, 32'h0000);
      local_read(10'd8, rv);
      chk("otg_rst_mem8", {16'b0, rv}, 32'hBEEF);
      local_read(10'd1023, rv);
      chk("otg_rst_mem_top", {16'b0, rv}, 32'h1234);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
